// File: rtl/adder_arb_pkg.sv
//------------------------------------------------------------------------------
// adder_arb_pkg
// Shared constants and the round-robin pick function for adder_arb8.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package adder_arb_pkg;

  localparam int ADD_W    = 8;
  localparam int ADD_NREQ = 4;
  // The pick function is sized for the largest supported requester count.
  localparam int RR_MAXN  = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First index with valid set, searching upward from ptr and wrapping at nreq.
  // The loop runs from the far end down so the nearest candidate is written last.
  function automatic rr_pick_t rr_pick(input logic [RR_MAXN-1:0] valid,
                                       input logic [2:0]         ptr,
                                       input int                 nreq);
    rr_pick_t   res;
    logic [3:0] idx;
    res = '0;
    for (int k = RR_MAXN - 1; k >= 0; k--) begin
      if (k < nreq) begin
        idx = {1'b0, ptr} + 4'(k);
        if (idx >= 4'(nreq)) begin
          idx = idx - 4'(nreq);
        end
        if (valid[idx[2:0]]) begin
          res.found = 1'b1;
          res.idx   = idx[2:0];
        end
      end
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/adder_arb8_add_stage8.sv
//------------------------------------------------------------------------------
// add_stage8
// Registered W+1-bit adder with load enable; also captures the requester id.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module add_stage8
  import adder_arb_pkg::*;
#(
  parameter int W   = ADD_W,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [IDW-1:0] id,
  output logic [W-1:0]   sum,
  output logic           carry,
  output logic [IDW-1:0] id_q
);

  // Load sum, carry and id on enable; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum   <= '0;
      carry <= 1'b0;
      id_q  <= '0;
    end else if (en) begin
      {carry, sum} <= {1'b0, a} + {1'b0, b};
      id_q         <= id;
    end
  end

endmodule

`default_nettype wire

// File: rtl/adder_arb8.sv
//------------------------------------------------------------------------------
// adder_arb8
// Round-robin arbiter sharing one registered adder among NREQ requesters.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module adder_arb8
  import adder_arb_pkg::*;
#(
  parameter int NREQ = ADD_NREQ,
  parameter int W    = ADD_W,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_sum,
  output logic              rsp_carry
);

  logic                r_rsp_valid;
  logic [IDW-1:0]      r_ptr;

  logic                w_advance;
  logic [RR_MAXN-1:0]  w_valid_ext;
  rr_pick_t            w_pick;
  logic                w_pick_unused;
  logic                w_grant;
  logic [IDW-1:0]      w_win;
  logic [IDW-1:0]      w_ptr_next;
  logic [W-1:0]        w_a;
  logic [W-1:0]        w_b;

  // The output slot can take a new result when empty or being drained.
  assign w_advance   = !r_rsp_valid || rsp_ready;

  assign w_valid_ext = RR_MAXN'(req_valid);
  assign w_pick      = rr_pick(w_valid_ext, 3'(r_ptr), NREQ);
  assign w_win       = IDW'(w_pick.idx);
  // Upper index bits are always zero when IDW < 3.
  assign w_pick_unused = &{1'b0, w_pick.idx};
  assign w_grant     = w_pick.found && w_advance;

  // Explicit wrap keeps non-power-of-2 requester counts in range.
  assign w_ptr_next  = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + 1'b1;

  // Operand mux; driven by the winner only, never feeds back into ready.
  assign w_a = req_a[int'(w_win) * W +: W];
  assign w_b = req_b[int'(w_win) * W +: W];

  // One-hot accept to the winner when the slot advances; silent in reset.
  always_comb begin
    req_ready = '0;
    if (w_grant && rst_n) begin
      req_ready[w_win] = 1'b1;
    end
  end

  // Round-robin pointer and result-valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      if (w_grant) begin
        r_ptr <= w_ptr_next;
      end
      if (w_advance) begin
        r_rsp_valid <= w_grant;
      end
    end
  end

  add_stage8 #(
    .W   (W),
    .IDW (IDW)
  ) u_add (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_grant),
    .a     (w_a),
    .b     (w_b),
    .id    (w_win),
    .sum   (rsp_sum),
    .carry (rsp_carry),
    .id_q  (rsp_id)
  );

  assign rsp_valid = r_rsp_valid;

endmodule

`default_nettype wire

// File: tb/tb_adder_arb8.sv
//------------------------------------------------------------------------------
// tb_adder_arb8
// Scoreboard bench for adder_arb8 with directed and random stimulus.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_adder_arb8;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              rsp_carry;

  always #5 clk = ~clk;

  adder_arb8 #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry)
  );

  int checks   = 0;
  int failures = 0;
  int exp_q[$];

  // Requester-side state: a request stays pending until it is accepted.
  bit pend[NREQ];
  int opa[NREQ];
  int opb[NREQ];

  // Reference model of the response slot and fairness pointer.
  int m_ptr;
  bit m_valid;
  int m_id, m_sum, m_carry;
  int last_gnt;
  int sum_hold;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]       = pend[i];
      req_a[i*W +: W]    = W'(opa[i]);
      req_b[i*W +: W]    = W'(opb[i]);
    end
  endtask

  task automatic raise(int i, int a, int b);
    pend[i] = 1'b1;
    opa[i]  = a;
    opb[i]  = b;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_id = 0; m_sum = 0; m_carry = 0;
    exp_q.delete();
  endtask

  // One clock: apply inputs, check outputs against the model mid-cycle,
  // advance the model across the edge, and retire accepted requests.
  task automatic cycle(bit refill);
    int win;
    bit adv;
    logic [NREQ-1:0] exp_rdy;
    int s;
    drive();
    @(negedge clk);
    chk("rsp_valid", int'(rsp_valid), m_valid);
    chk("rsp_id", int'(rsp_id), m_id);
    chk("rsp_sum", int'(rsp_sum), m_sum);
    chk("rsp_carry", int'(rsp_carry), m_carry);
    adv = !m_valid || rsp_ready;
    win = -1;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (pend[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
    end
    exp_rdy = '0;
    if (adv && win >= 0) exp_rdy[win] = 1'b1;
    chk("req_ready", int'(req_ready), int'(exp_rdy));
    last_gnt = -1;
    for (int i = 0; i < NREQ; i++) if (req_ready[i]) last_gnt = i;
    if (adv) begin
      if (win >= 0) begin
        s       = opa[win] + opb[win];
        m_id    = win;
        m_sum   = s % 256;
        m_carry = s / 256;
        exp_q.push_back((win << 9) | s);
        m_ptr   = (win + 1) % NREQ;
        m_valid = 1;
      end else begin
        m_valid = 0;
      end
    end
    @(posedge clk);
    #1;
    if (adv && win >= 0) begin
      pend[win] = 1'b0;
      if (refill) raise(win, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    end
  endtask

  // Scoreboard monitor: every accepted response is matched in issue order.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow actual=response required=none_expected");
      end else begin
        chk("sb_result", int'({rsp_id, rsp_carry, rsp_sum}), exp_q.pop_front());
      end
    end
  end

  // Requesters never withdraw: anything not accepted must still be held.
  logic [NREQ-1:0]   hold_q = '0;
  logic [NREQ*W-1:0] a_q, b_q;
  always @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (hold_q[i]) begin
        checks++;
        assert (req_valid[i] && req_a[i*W +: W] == a_q[i*W +: W] && req_b[i*W +: W] == b_q[i*W +: W])
        else begin
          failures++;
          $display("FAIL withdraw_%0d actual=%0b required=1", i, req_valid[i]);
        end
      end
    end
    hold_q <= req_valid & ~req_ready;
    a_q    <= req_a;
    b_q    <= req_b;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin pend[i] = 0; opa[i] = 0; opb[i] = 0; end
    model_reset();
    for (int i = 0; i < NREQ; i++) raise(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    drive();
    @(posedge clk);
    #1;
    chk("reset_valid", int'(rsp_valid), 0);
    chk("reset_sum", int'(rsp_sum), 0);
    chk("reset_id", int'(rsp_id), 0);
    chk("reset_ready", int'(req_ready), 0);
    rst_n = 1'b1;

    // All four valid with the consumer always ready: strict rotation.
    rsp_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      cycle(1);
      chk("rr_order", last_gnt, n % NREQ);
    end
    repeat (5) cycle(0);

    // Single requester and carry-out cases.
    raise(2, 'h12, 'h34);
    cycle(0);
    chk("single_gnt", last_gnt, 2);
    chk("single_valid", int'(rsp_valid), 1);
    chk("single_id", int'(rsp_id), 2);
    chk("single_sum", int'(rsp_sum), 'h46);
    chk("single_carry", int'(rsp_carry), 0);
    raise(1, 'hFF, 'h01);
    cycle(0);
    chk("ovf1_sum", int'(rsp_sum), 'h00);
    chk("ovf1_carry", int'(rsp_carry), 1);
    raise(0, 'h80, 'h80);
    cycle(0);
    chk("ovf2_sum", int'(rsp_sum), 'h00);
    chk("ovf2_carry", int'(rsp_carry), 1);

    // Backpressure: nothing granted, result held, then drain+grant together.
    rsp_ready = 1'b0;
    sum_hold  = int'(rsp_sum);
    raise(0, int'($urandom_range(0, 255)), 7);
    raise(1, int'($urandom_range(0, 255)), 9);
    raise(3, int'($urandom_range(0, 255)), 11);
    repeat (3) begin
      cycle(0);
      chk("bp_no_grant", last_gnt, -1);
      chk("bp_sum_hold", int'(rsp_sum), sum_hold);
    end
    rsp_ready = 1'b1;
    cycle(0);
    chk("bp_resume_gnt", last_gnt, 1);
    repeat (2) cycle(0);

    // Sparse: move the pointer to 2, then requesters 1 and 3 compete.
    raise(1, 1, 2);
    cycle(0);
    raise(1, 3, 4);
    raise(3, 5, 6);
    cycle(0);
    chk("sparse_first", last_gnt, 3);
    cycle(0);
    chk("sparse_wrap", last_gnt, 1);
    cycle(0);

    // Reset in the middle of a held result.
    rsp_ready = 1'b0;
    raise(0, 'h20, 'h0A);
    cycle(0);
    chk("pre_rst_sum", int'(rsp_sum), 'h2A);
    rst_n = 1'b0;
    #1;
    chk("rst_valid", int'(rsp_valid), 0);
    chk("rst_sum", int'(rsp_sum), 0);
    chk("rst_id", int'(rsp_id), 0);
    chk("rst_ready", int'(req_ready), 0);
    model_reset();
    for (int i = 0; i < NREQ; i++) raise(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    drive();
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    cycle(0);
    chk("post_rst_gnt", last_gnt, 0);
    repeat (4) cycle(0);

    // Random traffic with random backpressure.
    repeat (400) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1)
          raise(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      end
      rsp_ready = ($urandom_range(0, 9) < 7);
      cycle(0);
    end
    rsp_ready = 1'b1;
    repeat (8) cycle(0);
    chk("sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
